// File: rtl/decoder_3to8_seq.sv
// Registered one-hot decoder with valid/ready on both sides and a built-in
// walking-one sweep generator that emits every one-hot code in order.
module decoder_3to8_seq #(
  parameter int IN_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_idx,
  input  logic                   in_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(2**IN_W)-1:0]   out_data,
  output logic [IN_W-1:0]        out_idx,
  input  logic                   sweep_start,
  output logic                   sweep_busy,
  output logic                   sweep_done
);

  localparam int              OUT_W    = 2**IN_W;
  localparam logic [IN_W-1:0] CNT_LAST = IN_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [IN_W-1:0]     cnt_r;
  logic [IN_W-1:0]     cnt_nxt_s;
  logic                out_valid_r;
  logic [OUT_W-1:0]    out_data_r;
  logic [IN_W-1:0]     out_idx_r;
  logic                slot_free_s;
  logic                load_s;
  logic [OUT_W-1:0]    load_data_s;
  logic [IN_W-1:0]     load_idx_s;
  logic                in_ready_s;
  logic                sweep_done_s;

  function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] idx,
                                              input logic            en);
    logic [OUT_W-1:0] word;
    word = '0;
    if (en) begin
      word[idx] = 1'b1;
    end else begin
      word = '0;
    end
    return word;
  endfunction

  // Next-state, slot load selection and handshake outputs.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    load_s       = 1'b0;
    load_data_s  = '0;
    load_idx_s   = '0;
    in_ready_s   = 1'b0;
    sweep_done_s = 1'b0;
    slot_free_s  = !out_valid_r || out_ready;

    case (state_r)
      ST_IDLE: begin
        in_ready_s = slot_free_s;
        if (in_valid && slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = onehot(in_idx, in_en);
          load_idx_s  = in_idx;
        end else begin
          load_s = 1'b0;
        end
        // A same-cycle user word is loaded above and thus precedes the sweep.
        if (sweep_start) begin
          state_nxt_s = ST_SWEEP;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = onehot(cnt_r, 1'b1);
          load_idx_s  = cnt_r;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            cnt_nxt_s = cnt_r + {{(IN_W-1){1'b0}}, 1'b1};
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (out_valid_r && out_ready) begin
          sweep_done_s = 1'b1;
          state_nxt_s  = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Output slot: refill when free, otherwise hold until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_idx_r   <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= load_data_s;
      out_idx_r   <= load_idx_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_idx    = out_idx_r;
  assign sweep_busy = (state_r != ST_IDLE);
  assign sweep_done = sweep_done_s;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Directed plus randomized bench for decoder_3to8_seq, checked every cycle
// against a queue-based model of the output word stream.
module tb_decoder_3to8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic       in_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic       sweep_start;
  logic       sweep_busy;
  logic       sweep_done;

  int checks   = 0;
  int failures = 0;

  // Model: one output slot plus a queue of sweep indices still to emit.
  logic       m_v;
  logic [7:0] m_data;
  logic [2:0] m_idx;
  logic       m_last;
  int         sweep_q[$];

  decoder_3to8_seq #(.IN_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_en(in_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int enc(input logic [7:0] d);
    int r = -1;
    for (int b = 0; b < 8; b++) if (d[b] === 1'b1) r = b;
    return r;
  endfunction

  function automatic logic m_busy();
    return (sweep_q.size() != 0) || m_last;
  endfunction

  task automatic m_load(input logic [7:0] d, input logic [2:0] i, input logic last);
    m_v = 1'b1; m_data = d; m_idx = i; m_last = last;
  endtask

  task automatic model_edge();
    logic free;
    int   j;
    free = !m_v || out_ready;
    if (rst) begin
      m_v = 1'b0; m_data = 8'h00; m_idx = 3'd0; m_last = 1'b0;
      sweep_q.delete();
    end else if (!m_busy()) begin
      if (in_valid && free) m_load(in_en ? 8'(1 << in_idx) : 8'h00, in_idx, 1'b0);
      else if (out_ready) m_v = 1'b0;
      if (sweep_start) for (int i = 0; i < 8; i++) sweep_q.push_back(i);
    end else begin
      if (sweep_q.size() > 0 && free) begin
        j = sweep_q.pop_front();
        m_load(8'(1 << j), 3'(j), sweep_q.size() == 0);
      end else if (m_v && out_ready) begin
        m_v = 1'b0; m_last = 1'b0;
      end
    end
  endtask

  // Compare at the falling edge, advance the model at the rising edge.
  task automatic tick(input bit do_chk);
    @(negedge clk);
    if (do_chk) begin
      chk("out_valid",  out_valid,  m_v);
      chk("out_data",   out_data,   m_data);
      chk("out_idx",    out_idx,    m_idx);
      chk("in_ready",   in_ready,   !m_busy() && (!m_v || out_ready));
      chk("sweep_busy", sweep_busy, m_busy());
      chk("sweep_done", sweep_done, m_last && m_v && out_ready);
      if (m_v && m_data != 8'h00) begin
        chk("roundtrip",  enc(out_data), m_idx);
        chk("countones",  $countones(out_data), 1);
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    m_v = 1'b0; m_data = 8'h00; m_idx = 3'd0; m_last = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_idx = 3'd0; in_en = 1'b0;
    out_ready = 1'b0; sweep_start = 1'b0;
    tick(0);
    tick(1);
    rst = 1'b0;

    // Directed decode of every index, then a disabled decode.
    out_ready = 1'b1; in_valid = 1'b1; in_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_idx = 3'(i);
      tick(1);
    end
    in_idx = 3'd5; in_en = 1'b0;
    tick(1);
    in_valid = 1'b0; in_en = 1'b1;
    tick(1);

    // Backpressure with two back-to-back words.
    out_ready = 1'b0; in_valid = 1'b1; in_idx = 3'd3;
    tick(1);
    in_idx = 3'd6;
    for (int k = 0; k < 4; k++) tick(1);
    out_ready = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(1);
    tick(1);

    // Sweep at full rate, with input and a second start ignored mid-sweep.
    sweep_start = 1'b1;
    tick(1);
    in_valid = 1'b1; in_idx = 3'd2;
    for (int k = 0; k < 11; k++) begin
      sweep_start = (k == 3);
      tick(1);
    end
    in_valid = 1'b0; sweep_start = 1'b0;

    // Sweep with a word pending and a toggling consumer.
    out_ready = 1'b0; in_valid = 1'b1; in_idx = 3'd4; sweep_start = 1'b1;
    tick(1);
    in_valid = 1'b0; sweep_start = 1'b0;
    for (int k = 0; k < 22; k++) begin
      out_ready = (k % 2 == 0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);

    // Reset after the third sweep word, then restart.
    sweep_start = 1'b1;
    tick(1);
    sweep_start = 1'b0;
    for (int k = 0; k < 3; k++) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    sweep_start = 1'b1;
    tick(1);
    sweep_start = 1'b0;
    for (int k = 0; k < 10; k++) tick(1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_idx      = 3'($urandom_range(0, 7));
      in_en       = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      sweep_start = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_seq.md
Name: decoder_3to8_seq

Overview:
- Registered one-hot decoder. Converts an index of IN_W bits into a 2**IN_W one-hot word, with valid/ready flow control on both sides.
- A built-in sweep mode emits every one-hot code 0..2**IN_W-1 in order. This drives walking-one patterns into downstream logic and round-trip checks against the 8-to-3 priority encoder.
- Sits between a control/stimulus source and any consumer of one-hot selects.

Parameters:
- IN_W, 3, index width; output width OUT_W = 2**IN_W (derived, not overridable).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  index present on in_idx/in_en
- in_ready  output  1  block accepts index this cycle
- in_idx  input  IN_W  index to decode
- in_en  input  1  decoder enable; 0 decodes to all-zeros
- out_valid  output  1  out_data/out_idx hold a decoded word
- out_ready  input  1  consumer takes word this cycle
- out_data  output  OUT_W  one-hot result (or zero)
- out_idx  output  IN_W  index that produced out_data
- sweep_start  input  1  single-cycle request to start a sweep
- sweep_busy  output  1  high in states SWEEP and DRAIN
- sweep_done  output  1  one-cycle pulse when the last sweep word is consumed

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid=0, out_data=0, out_idx=0, sweep_busy=0, sweep_done=0.
  - Sweep counter=0, state=IDLE.
  - Reset mid-sweep or with a word pending discards everything. No partial flush.
- Output slot:
  - Single register. slot_free = !out_valid || out_ready (same-cycle refill allowed).
  - A word on out_data stays stable until out_valid && out_ready.
- Handshakes:
  - Input handshake = in_valid && in_ready. Output handshake = out_valid && out_ready.
  - Latency: the word is visible on out_data exactly 1 cycle after the input handshake. Full throughput is 1 word/cycle with out_ready held high.
- Decode:
  - out_data = in_en ? (1 << in_idx) : 0.
  - out_idx = in_idx, captured even when in_en=0.
  - Exactly one bit set when in_en=1.
- FSM:
  - IDLE: in_ready = slot_free. If sweep_start=1, go to SWEEP; counter=0. An input handshake in the same cycle is still loaded and precedes all sweep words.
  - SWEEP: in_ready=0 and in_valid is ignored. Each cycle slot_free=1, load out_data=1<<counter, out_idx=counter, out_valid=1. After loading counter=OUT_W-1, go to DRAIN; otherwise increment the counter.
  - DRAIN: in_ready=0. On the output handshake of the last word, pulse sweep_done=1 for that cycle and go to IDLE next cycle.
  - sweep_start in SWEEP or DRAIN is ignored. There is no queuing.
- Sweep start with a word pending:
  - The pending word is delivered first, unchanged.
  - The sweep's first word loads on the cycle it is consumed.
- Backpressure: out_ready low for any duration stalls with no loss, duplication or reorder.
- Counter: IN_W bits, no wrap beyond OUT_W-1 within one sweep. Reset to 0 on every new sweep.
- sweep_done never asserts outside DRAIN. sweep_busy deasserts on the cycle after sweep_done.

Test Plan:
- Directed decode: for i=0..7 send in_idx=i, in_en=1, out_ready=1 → out_data=8'b1<<i, out_idx=i, one cycle after each accept. Then send in_idx=5, in_en=0 → out_data=8'h00, out_idx=5.
- Round trip: feed out_data through encoder_8to3 for i=0..7 → encoder output equals in_idx every time. Also check $countones(out_data)==1.
- Backpressure: send idx 3,6 back-to-back, hold out_ready=0 for 4 cycles → in_ready=0 after the first word, out_data holds 8'h08. Release → 8'h08 then 8'h40, no drops.
- Sweep at full rate: sweep_start with out_ready=1 → out_data 01,02,04,...,80 on 8 consecutive cycles. sweep_done is high on the cycle 80 is taken. in_ready=0 throughout. A sweep_start pulsed mid-sweep has no effect.
- Sweep with stall: out_ready toggles 1,0,1,0 → all 8 words in order exactly once. sweep_done coincides with the final handshake only.
- Reset mid-sweep: assert rst after the 3rd word → next cycle out_valid=0, out_data=0, sweep_busy=0. A new sweep_start restarts from 8'h01.
